// File: rtl/segasys1_sndcmd_queue.sv
// Sound command queue between the System 1 main-CPU block and the sound CPU.
// Ports: CLK48M/RESETn clock and async reset; SNDRQ/SNDNO command strobe and
// byte in; SRD sound CPU latch read; SND_NMI/SND_DO NMI and presented byte;
// FIFO_CNT queued entries; OVF sticky drop flag, cleared by OVF_CLR.
module segasys1_sndcmd_queue #(
    parameter int DEPTH = 4,
    parameter int GAP   = 96,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK48M,
    input  logic          RESETn,
    input  logic          SNDRQ,
    input  logic [7:0]    SNDNO,
    input  logic          SRD,
    output logic          SND_NMI,
    output logic [7:0]    SND_DO,
    output logic [AW:0]   FIFO_CNT,
    output logic          OVF,
    input  logic          OVF_CLR
);

    localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          nmi_q, nmi_d;
    logic [7:0]    do_q, do_d;
    logic          ovf_q, ovf_d;
    logic          sndrq_q;
    logic          srd_q;

    logic push, srd_rise, pop, full, wr_en, drop;

    always_comb begin
        push     = SNDRQ & ~sndrq_q;
        srd_rise = SRD & ~srd_q;
        pop      = srd_rise & (state_q == S_ASSERT);
        full     = (cnt_q == (AW+1)'(DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        wr_en    = push & (~full | pop);
        drop     = push & full & ~pop;

        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        nmi_d   = nmi_q;
        do_d    = do_q;
        ovf_d   = ovf_q;
        state_d = state_q;

        if (wr_en) begin
            mem_d[wp_q] = SNDNO;
            wp_d        = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end

        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    do_d    = mem_q[rp_q];
                    nmi_d   = 1'b1;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (pop) begin
                    nmi_d   = 1'b0;
                    gap_d   = GW'(GAP - 1);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                nmi_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            nmi_q   <= 1'b0;
            do_q    <= '0;
            ovf_q   <= 1'b0;
            sndrq_q <= 1'b0;
            srd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            nmi_q   <= nmi_d;
            do_q    <= do_d;
            ovf_q   <= ovf_d;
            sndrq_q <= SNDRQ;
            srd_q   <= SRD;
        end
    end

    assign SND_NMI  = nmi_q;
    assign SND_DO   = do_q;
    assign FIFO_CNT = cnt_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_segasys1_sndcmd_queue.sv
// Testbench for segasys1_sndcmd_queue: vector table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_segasys1_sndcmd_queue;

    localparam int DEPTH = 4;
    localparam int GAP   = 96;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sndrq = 1'b0;
    logic [7:0] sndno = '0;
    logic       srd = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       snd_nmi;
    logic [7:0] snd_do;
    logic [2:0] fifo_cnt;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    segasys1_sndcmd_queue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .CLK48M   (clk),
        .RESETn   (rst_n),
        .SNDRQ    (sndrq),
        .SNDNO    (sndno),
        .SRD      (srd),
        .SND_NMI  (snd_nmi),
        .SND_DO   (snd_do),
        .FIFO_CNT (fifo_cnt),
        .OVF      (ovf),
        .OVF_CLR  (ovf_clr)
    );

    // Reference model: a byte queue plus "is an NMI pending" and the cycle
    // number of the last acknowledge.
    logic [7:0] mq[$];
    bit         m_nmi;
    logic [7:0] m_do;
    bit         m_ovf;
    int         m_cyc;
    int         m_ack;
    bit         m_prq;
    bit         m_psrd;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_nmi  = 0;
        m_do   = 8'h00;
        m_ovf  = 0;
        m_ack  = -100000;
        m_prq  = 0;
        m_psrd = 0;
    endtask

    task automatic model_step(input bit rq, input logic [7:0] no,
                              input bit rd, input bit clr);
        bit push, rise, pop;
        int pre;
        m_cyc++;
        push = rq & !m_prq;
        rise = rd & !m_psrd;
        pop  = rise & m_nmi;
        pre  = mq.size();
        if (pop) begin
            void'(mq.pop_front());
            m_nmi = 0;
            m_ack = m_cyc;
        end else if (!m_nmi && pre > 0 && (m_cyc - m_ack) >= GAP + 1) begin
            m_nmi = 1;
            m_do  = mq[0];
        end
        if (push && (pre < DEPTH || pop)) mq.push_back(no);
        if (push && pre == DEPTH && !pop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_prq  = rq;
        m_psrd = rd;
    endtask

    task automatic cycle(input bit rq, input logic [7:0] no,
                         input bit rd, input bit clr);
        sndrq   = rq;
        sndno   = no;
        srd     = rd;
        ovf_clr = clr;
        @(posedge clk);
        model_step(rq, no, rd, clr);
        #1;
        check("m_nmi", snd_nmi, m_nmi);
        check("m_do", snd_do, m_do);
        check("m_cnt", fifo_cnt, mq.size());
        check("m_ovf", ovf, m_ovf);
    endtask

    task automatic push_byte(input logic [7:0] b);
        cycle(1, b, 0, 0);
        cycle(1, b, 0, 0);
        cycle(0, b, 0, 0);
    endtask

    task automatic wait_nmi(output int k);
        k = 0;
        while (!snd_nmi && k < 400) begin
            cycle(0, 8'h00, 0, 0);
            k++;
        end
        check("nmi_wait", snd_nmi, 1);
    endtask

    task automatic ack();
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        sndrq = 0; srd = 0; ovf_clr = 0; sndno = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_nmi", snd_nmi, 0);
        check("rst_do", snd_do, 8'h00);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_ovf", ovf, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rq;
        logic [7:0] no;
        bit         rd;
        bit         clr;
        int         reps;
        bit         e_nmi;
        logic [7:0] e_do;
        int         e_cnt;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int k;
        logic [7:0] eq[$];

        tbl[0] = '{1, 8'h3A, 0, 0,   1, 0, 8'h00, 1, 0};
        tbl[1] = '{1, 8'h3A, 0, 0,  15, 1, 8'h3A, 1, 0};
        tbl[2] = '{0, 8'h00, 0, 0,   3, 1, 8'h3A, 1, 0};
        tbl[3] = '{0, 8'h00, 1, 0,   1, 0, 8'h3A, 0, 0};
        tbl[4] = '{0, 8'h00, 1, 0,   2, 0, 8'h3A, 0, 0};
        tbl[5] = '{0, 8'h00, 0, 0,   2, 0, 8'h3A, 0, 0};
        tbl[6] = '{0, 8'h00, 1, 0,   2, 0, 8'h3A, 0, 0};
        tbl[7] = '{0, 8'h00, 0, 0, 110, 0, 8'h3A, 0, 0};
        tbl[8] = '{0, 8'h00, 1, 0,   2, 0, 8'h3A, 0, 0};
        tbl[9] = '{0, 8'h00, 0, 0,   2, 0, 8'h3A, 0, 0};

        m_cyc = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_nmi", snd_nmi, 0);
        check("init_do", snd_do, 8'h00);
        check("init_cnt", fifo_cnt, 0);
        check("init_ovf", ovf, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single command, spurious reads in GAP and in IDLE.
        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                cycle(tbl[i].rq, tbl[i].no, tbl[i].rd, tbl[i].clr);
                check($sformatf("tbl%0d_nmi", i), snd_nmi, tbl[i].e_nmi);
                check($sformatf("tbl%0d_do", i), snd_do, tbl[i].e_do);
                check($sformatf("tbl%0d_cnt", i), fifo_cnt, tbl[i].e_cnt);
                check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].e_ovf);
            end
        end

        // Burst of three with ack spacing.
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        check("burst_cnt", fifo_cnt, 3);
        check("burst_do", snd_do, 8'h01);
        for (int i = 1; i <= 3; i++) begin
            wait_nmi(k);
            if (i > 1) check("burst_gap", k + 1, GAP + 1);
            check("burst_order", snd_do, i);
            ack();
        end

        // Overflow.
        do_reset();
        for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
        check("ovf_cnt", fifo_cnt, 4);
        check("ovf_set", ovf, 1);
        for (int i = 0; i < 4; i++) begin
            wait_nmi(k);
            check("ovf_order", snd_do, 8'h10 + 8'(i));
            ack();
        end
        repeat (150) cycle(0, 8'h00, 0, 0);
        check("ovf_drain_nmi", snd_nmi, 0);
        check("ovf_drain_cnt", fifo_cnt, 0);
        check("ovf_sticky", ovf, 1);
        cycle(0, 8'h00, 0, 1);
        check("ovf_clr", ovf, 0);

        // Simultaneous push and pop while full, then wrap-around.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h20 + 8'(i));
            eq.push_back(8'h20 + 8'(i));
        end
        check("sim_full", fifo_cnt, 4);
        for (int i = 0; i < 10; i++) begin
            wait_nmi(k);
            check("sim_order", snd_do, eq.pop_front());
            cycle(1, 8'hA0 + 8'(i), 1, 0);
            eq.push_back(8'hA0 + 8'(i));
            check("sim_cnt", fifo_cnt, 4);
            check("sim_ovf", ovf, 0);
            cycle(0, 8'h00, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_nmi(k);
            check("wrap_order", snd_do, eq.pop_front());
            ack();
        end

        // Asynchronous reset with bytes queued and NMI high.
        repeat (100) cycle(0, 8'h00, 0, 0);
        push_byte(8'h31);
        push_byte(8'h32);
        wait_nmi(k);
        check("mid_cnt", fifo_cnt, 2);
        check("mid_do", snd_do, 8'h31);
        do_reset();
        repeat (120) cycle(0, 8'h00, 0, 0);
        check("post_rst_nmi", snd_nmi, 0);
        check("post_rst_cnt", fifo_cnt, 0);

        // Randomized traffic: heavy push rate, then light to drain.
        begin
            int rq_left = 0;
            bit rq = 0;
            logic [7:0] no = '0;
            for (int c = 0; c < 4000; c++) begin
                if (rq_left > 0) begin
                    rq = 1;
                    rq_left--;
                end else begin
                    rq = 0;
                    if ($urandom_range(0, (c < 2000) ? 15 : 150) == 0) begin
                        rq_left = $urandom_range(1, 16);
                        no = 8'($urandom);
                    end
                end
                cycle(rq, no, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 63) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segasys1_sndcmd_queue.md
Name: segasys1_sndcmd_queue

Overview:
- Sits directly downstream of the System 1 main-CPU block, between its SNDRQ/SNDNO outputs and the sound CPU.
- Queues sound command bytes written by the main CPU in a small FIFO.
- Presents one byte at a time on the sound CPU's command-latch read port and raises the sound CPU NMI for each byte.
- Runs entirely in the CLK48M domain. SNDRQ/SNDNO come from CLK3M logic derived from CLK48M, so no synchroniser is needed.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, at least 2. AW = log2(DEPTH).
- GAP, 96, minimum CLK48M cycles NMI stays low after an acknowledge before the next NMI may assert (2 us).

Ports:
- CLK48M  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- SNDRQ  in  1  command strobe from main block; high for one CLK3M period (several CLK48M cycles)
- SNDNO  in  8  command byte; valid whenever SNDRQ=1
- SRD  in  1  sound CPU read of command latch (decoded CS & RD & MREQ), level, active high
- SND_NMI  out  1  NMI request to sound CPU, active high
- SND_DO  out  8  command byte presented to the sound CPU data selector
- FIFO_CNT  out  AW+1  number of queued, unacknowledged entries
- OVF  out  1  sticky: a command was dropped because the FIFO was full
- OVF_CLR  in  1  synchronous clear of OVF

Behaviour:
- Reset (RESETn=0, asynchronous):
  - SND_NMI=0, SND_DO=8'h00, FIFO_CNT=0, OVF=0.
  - State IDLE, gap counter 0, read pointer 0, write pointer 0.
  - Edge-detect registers for SNDRQ and SRD reset to 0.
  - Reset mid-ASSERT or mid-GAP discards all queued bytes and drops NMI immediately.
- Push:
  - push = SNDRQ & ~SNDRQ_d (rising edge). Exactly one push per strobe regardless of strobe length.
  - Writes SNDNO to mem[wp]; wp increments mod DEPTH.
- Push when full:
  - If FIFO_CNT==DEPTH and no pop occurs in the same cycle, the byte is dropped, OVF is set and the pointers are unchanged.
  - If a pop occurs in the same cycle, the push is accepted.
- OVF: set has priority over OVF_CLR in the same cycle.
- Pop:
  - pop = SRD rise & (state==ASSERT).
  - rp increments mod DEPTH.
  - SRD rises in IDLE or GAP are spurious: no pop; SND_DO is unchanged.
- FIFO_CNT:
  - push-only: +1.
  - pop-only: -1.
  - push and pop in the same cycle: unchanged.
  - Never exceeds DEPTH and never underflows.
- State machine:
  - IDLE: if FIFO_CNT>0, load SND_DO <= mem[rp], set SND_NMI=1, go to ASSERT.
  - ASSERT: SND_NMI held high, SND_DO held stable. On pop, SND_NMI=0, load the gap counter with GAP-1, go to GAP.
  - GAP: counter decrements every cycle; at 0 go to IDLE. SND_NMI=0. SND_DO retains the last presented byte, so repeated sound CPU reads return the same value.
- Latency: if SNDRQ is first sampled high at edge t, FIFO_CNT=1 after t and SND_NMI=1 with SND_DO=byte after t+1.
- Back-to-back spacing: minimum GAP+1 cycles from the acknowledge edge to the next SND_NMI rise.
- Ordering: strictly FIFO. The byte in SND_DO during ASSERT is always the oldest unacknowledged entry.
- Pointer wrap-around at DEPTH is seamless; FIFO full/empty is determined by FIFO_CNT, not by pointer equality.

Test Plan:
- Single command: reset, SNDRQ high 16 cycles with SNDNO=8'h3A -> FIFO_CNT=1, SND_NMI rises 2 cycles after the strobe, SND_DO=8'h3A. SRD pulse -> NMI low, FIFO_CNT=0. No second NMI after GAP. Second SRD returns 8'h3A.
- Burst: push 8'h01, 8'h02, 8'h03 before any read -> FIFO_CNT=3, SND_DO=8'h01. Three acks give 8'h01, 8'h02, 8'h03 in order, each NMI rise at least 97 cycles after the previous ack.
- Overflow (DEPTH=4): push 8'h10..8'h15 without reads -> FIFO_CNT=4, OVF=1. Reads return 8'h10..8'h13 only. OVF_CLR pulse -> OVF=0.
- Simultaneous: FIFO full with NMI asserted; SRD rise and SNDRQ rise in the same cycle -> new byte accepted, FIFO_CNT stays 4, OVF stays 0. Wrap-around ordering is preserved over 10 further commands.
- Spurious read: SRD pulses in IDLE with an empty FIFO and during GAP -> FIFO_CNT, state and SND_DO unchanged, no NMI.
- Reset mid-operation: 2 bytes queued, NMI high; RESETn low for 1 cycle asynchronously -> SND_NMI=0, SND_DO=8'h00, FIFO_CNT=0 immediately. After release with no push, NMI stays low.
